// File: rtl/fft_bank_scheduler.sv
// fft_bank_scheduler: ping-pong bank scheduler for the spectrum display path.
// Writes each complete FFT frame into the write half of a dual-bank RAM and
// swaps banks only on the rising edge of vsync. This prevents the display from
// tearing. It also sequences the display read point from data_req and
// fft_point_done.
// Optional feature macro: FFT_SCHED_STATS_EN (frame drop/error counters).
module fft_bank_scheduler #(
  parameter int unsigned POINTS = 512,
  parameter int unsigned AW     = 9,
  parameter int unsigned DW     = 9,
  parameter int unsigned CW     = 16
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic [DW-1:0] fft_data,
  input  logic          fft_valid,
  input  logic          fft_eop,
  input  logic          i_vs,
  input  logic          data_req,
  input  logic          fft_point_done,
  output logic          ram_wr_en,
  output logic [AW:0]   ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [AW:0]   ram_rd_addr,
  output logic [AW-1:0] fft_point_cnt,
  output logic          disp_valid,
  output logic [CW-1:0] frame_drop_cnt,
  output logic [CW-1:0] frame_err_cnt
);

  localparam logic [AW-1:0] LastPt = AW'(POINTS - 1);

  typedef enum logic [1:0] {WIdle, WFill, WDone} wr_state_e;

  wr_state_e     state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          full_q, full_d;      // frame ran past the last point without eop
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          disp_valid_q, disp_valid_d;
  logic [AW-1:0] pt_cnt_q, pt_cnt_d;
  logic          vs_d_q;
  logic          wr_en_q, wr_en_d;
  logic [AW:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          vs_rise;
  logic          swap;
  logic          drop_inc;
  logic          err_inc;
  logic [AW-1:0] cur_pt;
  logic          cur_bad;

  assign vs_rise = i_vs & ~vs_d_q;
  assign swap    = vs_rise && (state_q == WDone);

  // Writer FSM next state and registered RAM write port
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    cur_pt    = '0;
    cur_bad   = 1'b0;
    unique case (state_q)
      WIdle, WFill: begin
        if (fft_valid) begin
          // W_IDLE always starts a fresh frame at point 0
          cur_pt  = (state_q == WIdle) ? '0 : wr_cnt_q;
          cur_bad = (state_q == WFill) && full_q;
          if (!cur_bad) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, cur_pt};
            wr_data_d = fft_data;
          end
          if (fft_eop) begin
            full_d   = 1'b0;
            wr_cnt_d = '0;
            if (!cur_bad && (cur_pt == LastPt)) begin
              state_d = WDone;
            end else begin
              state_d = WIdle;
              err_inc = 1'b1;
            end
          end else begin
            state_d = WFill;
            if (cur_bad || (cur_pt == LastPt)) begin
              full_d = 1'b1;
            end else begin
              full_d   = 1'b0;
              wr_cnt_d = cur_pt + AW'(1);
            end
          end
        end
      end
      WDone: begin
        // Frame held until the display takes it; extra frames are discarded
        if (fft_valid && fft_eop) drop_inc = 1'b1;
        if (vs_rise) state_d = WIdle;
      end
      default: state_d = WIdle;
    endcase
  end

  // Bank swap at vsync and display point sequencing
  always_comb begin
    rd_bank_d    = rd_bank_q;
    wr_bank_d    = wr_bank_q;
    disp_valid_d = disp_valid_q;
    pt_cnt_d     = pt_cnt_q;
    if (swap) begin
      rd_bank_d    = wr_bank_q;
      wr_bank_d    = ~wr_bank_q;
      disp_valid_d = 1'b1;
    end
    if (swap || fft_point_done) begin
      pt_cnt_d = '0;
    end else if (data_req && (pt_cnt_q != LastPt)) begin
      pt_cnt_d = pt_cnt_q + AW'(1);
    end
  end

  // All scheduler state, cleared asynchronously
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WIdle;
      wr_cnt_q     <= '0;
      full_q       <= 1'b0;
      wr_bank_q    <= 1'b1;
      rd_bank_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      pt_cnt_q     <= '0;
      vs_d_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      disp_valid_q <= disp_valid_d;
      pt_cnt_q     <= pt_cnt_d;
      vs_d_q       <= i_vs;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign ram_wr_en     = wr_en_q;
  assign ram_wr_addr   = wr_addr_q;
  assign ram_wr_data   = wr_data_q;
  assign ram_rd_addr   = {rd_bank_q, pt_cnt_q};
  assign fft_point_cnt = pt_cnt_q;
  assign disp_valid    = disp_valid_q;

`ifdef FFT_SCHED_STATS_EN
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;

  // Saturating statistics counters
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CW'(1);
    if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CW'(1);
  end

  // Statistics counter registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign frame_drop_cnt = drop_cnt_q;
  assign frame_err_cnt  = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats   = drop_inc ^ err_inc;
  assign frame_drop_cnt = '0;
  assign frame_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_fft_bank_scheduler.sv
// Directed self-checking bench for fft_bank_scheduler.
module tb_fft_bank_scheduler;

`ifdef FFT_SCHED_STATS_EN
  localparam int StatsEn = 1;
`else
  localparam int StatsEn = 0;
`endif

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [8:0]  fft_data;
  logic        fft_valid;
  logic        fft_eop;
  logic        i_vs;
  logic        data_req;
  logic        fft_point_done;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [8:0]  ram_wr_data;
  logic [9:0]  ram_rd_addr;
  logic [8:0]  fft_point_cnt;
  logic        disp_valid;
  logic [15:0] frame_drop_cnt;
  logic [15:0] frame_err_cnt;

  int checks = 0;
  int errors = 0;

  // Write monitor state
  logic [8:0] mem [0:1023];
  int wr_n = 0;
  int wr_min = 9999;
  int wr_max = -1;
  int rd_bank_wr = 0;

  fft_bank_scheduler #(
    .POINTS(512),
    .AW(9),
    .DW(9),
    .CW(16)
  ) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .fft_data(fft_data),
    .fft_valid(fft_valid),
    .fft_eop(fft_eop),
    .i_vs(i_vs),
    .data_req(data_req),
    .fft_point_done(fft_point_done),
    .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr),
    .fft_point_cnt(fft_point_cnt),
    .disp_valid(disp_valid),
    .frame_drop_cnt(frame_drop_cnt),
    .frame_err_cnt(frame_err_cnt)
  );

  always #5 pclk = ~pclk;

  // RAM model and write statistics, sampled mid-cycle
  always @(negedge pclk) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_n <= wr_n + 1;
      if (int'(ram_wr_addr) < wr_min) wr_min <= int'(ram_wr_addr);
      if (int'(ram_wr_addr) > wr_max) wr_max <= int'(ram_wr_addr);
      if (ram_wr_addr[9] == ram_rd_addr[9]) rd_bank_wr <= rd_bank_wr + 1;
    end
  end

  function automatic logic [8:0] pat(input int sel, input int i);
    case (sel)
      0:       pat = 9'(i * 3 + 1);
      1:       pat = 9'(i) ^ 9'h155;
      default: pat = 9'(i + 7);
    endcase
  endfunction

  task automatic clr_mon();
    wr_n   = 0;
    wr_min = 9999;
    wr_max = -1;
  endtask

  task automatic drive_sample(input logic [8:0] d, input logic eop);
    @(posedge pclk); #1;
    fft_valid = 1'b1;
    fft_data  = d;
    fft_eop   = eop;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      fft_valid = 1'b0;
      fft_eop   = 1'b0;
    end
  endtask

  // eop_at is 1-based; 0 means no eop
  task automatic send_frame(input int n, input int eop_at, input int sel);
    for (int i = 0; i < n; i++) drive_sample(pat(sel, i), (i == eop_at - 1));
  endtask

  task automatic vs_pulse();
    @(posedge pclk); #1 i_vs = 1'b1;
    @(posedge pclk); #1 i_vs = 1'b0;
  endtask

  task automatic req_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1 data_req = 1'b1;
      @(posedge pclk); #1 data_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fft_data = '0; fft_valid = 1'b0; fft_eop = 1'b0;
    i_vs = 1'b0; data_req = 1'b0; fft_point_done = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if ({ram_wr_en, ram_wr_addr, ram_wr_data} !== 20'd0) begin
      errors++; $display("FAIL reset_wr: got %h expected 0", {ram_wr_en, ram_wr_addr, ram_wr_data});
    end
    checks++;
    if (ram_rd_addr !== 10'd0 || fft_point_cnt !== 9'd0 || disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd: got rd %0d pt %0d dv %b expected 0 0 0",
               ram_rd_addr, fft_point_cnt, disp_valid);
    end
    checks++;
    if (frame_drop_cnt !== 16'd0 || frame_err_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d %0d expected 0 0", frame_drop_cnt, frame_err_cnt);
    end
    @(negedge pclk) rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    int bad;
    clr_mon();
    send_frame(512, 512, 0);
    idle(3);
    checks++;
    if (wr_n != 512 || wr_min != 512 || wr_max != 1023) begin
      errors++; $display("FAIL full_wr: got n %0d min %0d max %0d expected 512 512 1023",
                         wr_n, wr_min, wr_max);
    end
    bad = 0;
    for (int k = 0; k < 512; k++) if (mem[512 + k] !== pat(0, k)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_data: got %0d bad words expected 0", bad);
    end
    checks++;
    if (disp_valid !== 1'b0 || ram_rd_addr !== 10'd0) begin
      errors++; $display("FAIL full_preswap: got dv %b rd %0d expected 0 0", disp_valid, ram_rd_addr);
    end
    vs_pulse();
    checks++;
    if (disp_valid !== 1'b1 || ram_rd_addr !== 10'd512) begin
      errors++; $display("FAIL full_swap: got dv %b rd %0d expected 1 512", disp_valid, ram_rd_addr);
    end
  endtask

  task automatic test_short_frame();
    clr_mon();
    send_frame(300, 300, 1);
    idle(2);
    checks++;
    if (int'(frame_err_cnt) != StatsEn) begin
      errors++; $display("FAIL short_err: got %0d expected %0d", frame_err_cnt, StatsEn);
    end
    clr_mon();
    send_frame(512, 512, 1);
    idle(2);
    checks++;
    if (wr_n != 512 || wr_min != 0 || wr_max != 511) begin
      errors++; $display("FAIL short_restart: got n %0d min %0d max %0d expected 512 0 511",
                         wr_n, wr_min, wr_max);
    end
  endtask

  task automatic test_drop();
    int bad;
    clr_mon();
    send_frame(512, 512, 2);
    idle(2);
    checks++;
    if (wr_n != 0) begin
      errors++; $display("FAIL drop_writes: got %0d expected 0", wr_n);
    end
    checks++;
    if (int'(frame_drop_cnt) != StatsEn) begin
      errors++; $display("FAIL drop_cnt: got %0d expected %0d", frame_drop_cnt, StatsEn);
    end
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      if (mem[512 + k] !== pat(0, k)) bad++;
      if (mem[k] !== pat(1, k)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL drop_intact: got %0d bad words expected 0", bad);
    end
    vs_pulse();
    checks++;
    if (disp_valid !== 1'b1 || ram_rd_addr !== 10'd0) begin
      errors++; $display("FAIL drop_swap: got dv %b rd %0d expected 1 0", disp_valid, ram_rd_addr);
    end
  endtask

  task automatic test_eop_vs_same();
    clr_mon();
    send_frame(511, 0, 0);
    @(posedge pclk); #1;
    fft_valid = 1'b1; fft_data = pat(0, 511); fft_eop = 1'b1; i_vs = 1'b1;
    @(posedge pclk); #1;
    fft_valid = 1'b0; fft_eop = 1'b0; i_vs = 1'b0;
    idle(2);
    checks++;
    if (ram_rd_addr[9] !== 1'b0) begin
      errors++; $display("FAIL same_noswap: got bank %b expected 0", ram_rd_addr[9]);
    end
    checks++;
    if (wr_n != 512 || wr_min != 512) begin
      errors++; $display("FAIL same_wr: got n %0d min %0d expected 512 512", wr_n, wr_min);
    end
    vs_pulse();
    checks++;
    if (ram_rd_addr !== 10'd512) begin
      errors++; $display("FAIL same_swap: got %0d expected 512", ram_rd_addr);
    end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    send_frame(5, 5, 1);
    send_frame(512, 512, 1);
    idle(2);
    checks++;
    if (wr_n != 517 || wr_min != 0 || wr_max != 511) begin
      errors++; $display("FAIL b2b_wr: got n %0d min %0d max %0d expected 517 0 511",
                         wr_n, wr_min, wr_max);
    end
    checks++;
    if (int'(frame_err_cnt) != 2 * StatsEn) begin
      errors++; $display("FAIL b2b_err: got %0d expected %0d", frame_err_cnt, 2 * StatsEn);
    end
    vs_pulse();
    checks++;
    if (ram_rd_addr !== 10'd0) begin
      errors++; $display("FAIL b2b_swap: got %0d expected 0", ram_rd_addr);
    end
  endtask

  task automatic test_overlong();
    clr_mon();
    send_frame(520, 520, 2);
    idle(2);
    checks++;
    if (wr_n != 512 || wr_max != 1023) begin
      errors++; $display("FAIL long_wr: got n %0d max %0d expected 512 1023", wr_n, wr_max);
    end
    checks++;
    if (int'(frame_err_cnt) != 3 * StatsEn) begin
      errors++; $display("FAIL long_err: got %0d expected %0d", frame_err_cnt, 3 * StatsEn);
    end
    vs_pulse();
    checks++;
    if (ram_rd_addr !== 10'd0) begin
      errors++; $display("FAIL long_noswap: got %0d expected 0", ram_rd_addr);
    end
  endtask

  task automatic test_read_seq();
    req_pulses(3);
    checks++;
    if (fft_point_cnt !== 9'd3 || ram_rd_addr !== 10'd3) begin
      errors++; $display("FAIL rd_step: got pt %0d rd %0d expected 3 3", fft_point_cnt, ram_rd_addr);
    end
    req_pulses(597);
    checks++;
    if (fft_point_cnt !== 9'd511 || ram_rd_addr !== 10'd511) begin
      errors++; $display("FAIL rd_sat: got pt %0d rd %0d expected 511 511", fft_point_cnt, ram_rd_addr);
    end
    @(posedge pclk); #1 data_req = 1'b1; fft_point_done = 1'b1;
    @(posedge pclk); #1 data_req = 1'b0; fft_point_done = 1'b0;
    checks++;
    if (fft_point_cnt !== 9'd0) begin
      errors++; $display("FAIL rd_done_prio: got %0d expected 0", fft_point_cnt);
    end
    req_pulses(2);
    @(posedge pclk); #1 fft_point_done = 1'b1;
    @(posedge pclk); #1 fft_point_done = 1'b0;
    checks++;
    if (fft_point_cnt !== 9'd0) begin
      errors++; $display("FAIL rd_done: got %0d expected 0", fft_point_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    req_pulses(5);
    send_frame(200, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_wr_en, ram_wr_addr, ram_wr_data} !== 20'd0) begin
      errors++; $display("FAIL mid_rst_wr: got %h expected 0", {ram_wr_en, ram_wr_addr, ram_wr_data});
    end
    checks++;
    if (ram_rd_addr !== 10'd0 || fft_point_cnt !== 9'd0 || disp_valid !== 1'b0 ||
        frame_err_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_rst_rd: got rd %0d pt %0d dv %b err %0d expected 0 0 0 0",
                         ram_rd_addr, fft_point_cnt, disp_valid, frame_err_cnt);
    end
    fft_valid = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk) rst_n = 1'b1;
    clr_mon();
    send_frame(512, 512, 1);
    idle(2);
    checks++;
    if (disp_valid !== 1'b0 || wr_min != 512 || wr_n != 512) begin
      errors++; $display("FAIL mid_refill: got dv %b min %0d n %0d expected 0 512 512",
                         disp_valid, wr_min, wr_n);
    end
    vs_pulse();
    checks++;
    if (disp_valid !== 1'b1 || ram_rd_addr !== 10'd512) begin
      errors++; $display("FAIL mid_swap: got dv %b rd %0d expected 1 512", disp_valid, ram_rd_addr);
    end
    checks++;
    if (rd_bank_wr != 0) begin
      errors++; $display("FAIL rd_bank_write: got %0d writes to read bank expected 0", rd_bank_wr);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_drop();
    test_eop_vs_same();
    test_back_to_back();
    test_overlong();
    test_read_seq();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bank_scheduler.md
# fft_bank_scheduler

Ping-pong bank scheduler for the spectrum display path. It takes the magnitude stream (`fft_data`/`fft_valid`/`fft_eop`), already in the pixel-clock domain, and writes each complete FFT frame into one half of an external dual-bank spectrum RAM. It hands the other half to the display-side reader, and swaps banks only at the video frame boundary, so a bar graph never tears mid-frame. It also sequences the display's per-point read address from `data_req`/`fft_point_done`.

## Interface
- `POINTS`, 512, samples per FFT frame (power of two).
- `AW`, 9, point address width, log2(`POINTS`).
- `DW`, 9, magnitude width.
- `CW`, 16, statistics counter width.
- `pclk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fft_data`  in  DW  magnitude sample.
- `fft_valid`  in  1  sample valid.
- `fft_eop`  in  1  last sample of frame; only meaningful with `fft_valid`.
- `i_vs`  in  1  video vsync level, active high.
- `data_req`  in  1  display requests the next point (1-cycle pulse).
- `fft_point_done`  in  1  end of display line; restart the point sequence.
- `ram_wr_en`  out  1  RAM write enable.
- `ram_wr_addr`  out  AW+1  `{wr_bank, point}`.
- `ram_wr_data`  out  DW  write data.
- `ram_rd_addr`  out  AW+1  `{rd_bank, fft_point_cnt}`.
- `fft_point_cnt`  out  AW  current display point.
- `disp_valid`  out  1  read bank holds a complete frame.
- `frame_drop_cnt`  out  CW  complete frames discarded because no swap slot was free.
- `frame_err_cnt`  out  CW  malformed frames discarded.

## Operation
- **Reset values:** all outputs 0; internal `rd_bank`=0, `wr_bank`=1; writer state W_IDLE.
- **Writer FSM:**
  - W_IDLE: the first `fft_valid` writes at point 0, then goes to W_FILL.
  - W_FILL: each `fft_valid` writes at `wr_cnt` and increments it.
  - `fft_eop` with `wr_cnt == POINTS-1` goes to W_DONE (frame complete).
  - `fft_eop` at any other count discards the frame: `frame_err_cnt`++ and go to W_IDLE.
  - Samples after `wr_cnt` reaches `POINTS-1` without `eop` are not written. The frame is marked bad, and the next `eop` counts it as an error and returns to W_IDLE.
  - W_DONE: samples are ignored and not written. Each `fft_eop` seen here increments `frame_drop_cnt`. On the vsync swap, go to W_IDLE.
  - A single-sample frame (`valid`+`eop` in W_IDLE) is an error unless `POINTS`=1.
- **Swap:**
  - `vs_rise` = `i_vs` & ~`vs_d` (`vs_d` is registered).
  - On `vs_rise` in W_DONE: `rd_bank`<=`wr_bank`, `wr_bank`<=~`wr_bank`, `disp_valid`<=1, `fft_point_cnt`<=0.
  - On `vs_rise` in any other state: banks unchanged.
- **Reader sequencing:**
  - `fft_point_done` sets `fft_point_cnt` to 0. It has priority over a simultaneous `data_req`.
  - `data_req` increments `fft_point_cnt`, saturating at `POINTS-1`.
  - `ram_rd_addr` is a combinational concatenation of the registered `rd_bank` and `fft_point_cnt`.
- **Counters:** saturate at all-ones; they never wrap.

## Timing
- **Write latency:** `ram_wr_*` are registered, one cycle after the accepted `fft_valid`. `ram_wr_en` is never asserted to the read bank.
- **Swap latency:** `rd_bank`/`disp_valid` change on the `pclk` edge after the first cycle with `i_vs`=1.
- **`eop` and `vs_rise` in the same cycle:** `eop` completes the frame (enter W_DONE) but no swap occurs. The swap waits for the next vsync.
- **Back-to-back frames:** a new frame's first `fft_valid` the cycle after `eop` is accepted if the FSM is in W_IDLE. Otherwise that frame is dropped and counted at its `eop`.
- **Read latency:** `fft_point_cnt` updates one cycle after `data_req`. External RAM read latency is owned by the display.
- **Reset mid-frame:** all state is lost immediately. `disp_valid`=0 until the next complete frame has been swapped in.

## Configuration
- `FFT_SCHED_STATS_EN`:
  - Defined: `frame_drop_cnt`/`frame_err_cnt` are implemented as above.
  - Undefined: both outputs are tied to 0 and the counter logic is removed. FSM behaviour is identical.

## Test plan
- Reset, 512 valid samples with `eop` on the 512th, then a `vs_rise` → writes go to addresses 512..1023 (bank 1). One cycle after `vs_rise`: `rd_bank`=1, `disp_valid`=1, `ram_rd_addr`=512.
- `eop` on sample 300 → `frame_err_cnt`=1, FSM in W_IDLE, next frame starts at point 0.
- Two complete frames with no vsync between them → second frame produces no writes, `frame_drop_cnt`=1, bank 1 data intact.
- `eop` and `vs_rise` in the same cycle → no swap. Swap happens at the following `vs_rise`.
- 600 `data_req` pulses → `fft_point_cnt` saturates at 511. `data_req`+`fft_point_done` in the same cycle → `fft_point_cnt`=0.
- Assert `rst_n` low at sample 200 → all outputs 0 asynchronously. After release, a full frame and `vs_rise` → `disp_valid`=1, `rd_bank`=1.
